// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_ctrl_pkg                                           |
// | Description : Shared types for the memory access sequencer.          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAR    = 3'd1,
    WAIT   = 3'd2,
    MDR_LD = 3'd3,
    CAP    = 3'd4,
    MDR_ST = 3'd5,
    WR     = 3'd6,
    DONE   = 3'd7
  } mem_state_t;

  typedef struct packed {
    logic MARin;
    logic MDRin;
    logic MDRread;
    logic W_sig;
    logic BusDrive;
  } mem_strobes_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_access_ctrl_if                                     |
// | Description : CPU request port plus memory-subsystem strobes/bus.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              req;
  logic              wr;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] BusOut;
  logic              BusDrive;
  logic              MARin;
  logic              MDRin;
  logic              MDRread;
  logic              W_sig;
  logic [DATA_W-1:0] BusMuxInMDR;

  // Controller side.
  modport slave (
    input  req, wr, addr, wdata, BusMuxInMDR,
    output ready, done, err, rdata, BusOut, BusDrive, MARin, MDRin, MDRread, W_sig
  );

  // Requester / memory-subsystem side.
  modport master (
    output req, wr, addr, wdata, BusMuxInMDR,
    input  ready, done, err, rdata, BusOut, BusDrive, MARin, MDRin, MDRread, W_sig
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_access_ctrl                                        |
// | Description : Sequences single-word loads/stores into MAR/MDR/RAM    |
// |               strobes; one request in flight, done pulse on finish.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire logic          Clock,
  input  wire logic          Clear,
  mem_access_ctrl_if.slave   bus
);

  mem_state_t        rState, wNextState;
  mem_strobes_t      rStrobes, wNextStrobes;
  logic [DATA_W-1:0] rBusOut, wNextBusOut;
  logic              rDone, wNextDone;
  logic              rErr, wNextErr;
  logic              rWr;
  logic [DATA_W-1:0] rWdata;
  logic [DATA_W-1:0] rRdata;
  logic              wAddrOutOfRange;

  assign wAddrOutOfRange = |bus.addr[DATA_W-1:ADDR_W];

  // Outputs for the *next* state are decoded here and registered, so every
  // strobe comes straight from a flop.
  always_comb begin
    wNextState   = rState;
    wNextStrobes = '0;
    wNextBusOut  = '0;
    wNextDone    = 1'b0;
    wNextErr     = 1'b0;
    case (rState)
      IDLE: begin
        if (bus.req) begin
          if (wAddrOutOfRange) begin
            wNextState = DONE;
            wNextDone  = 1'b1;
            wNextErr   = 1'b1;
          end else begin
            wNextState            = MAR;
            wNextStrobes.MARin    = 1'b1;
            wNextStrobes.BusDrive = 1'b1;
            wNextBusOut           = bus.addr;
          end
        end
      end
      MAR: begin
        if (rWr) begin
          wNextState            = MDR_ST;
          wNextStrobes.MDRin    = 1'b1;
          wNextStrobes.BusDrive = 1'b1;
          wNextBusOut           = rWdata;
        end else begin
          wNextState = WAIT;
        end
      end
      WAIT: begin
        wNextState           = MDR_LD;
        wNextStrobes.MDRin   = 1'b1;
        wNextStrobes.MDRread = 1'b1;
      end
      MDR_LD: wNextState = CAP;
      CAP: begin
        wNextState = DONE;
        wNextDone  = 1'b1;
      end
      MDR_ST: begin
        wNextState         = WR;
        wNextStrobes.W_sig = 1'b1;
      end
      WR: begin
        wNextState = DONE;
        wNextDone  = 1'b1;
      end
      DONE:    wNextState = IDLE;
      default: wNextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      rState   <= IDLE;
      rStrobes <= '0;
      rBusOut  <= '0;
      rDone    <= 1'b0;
      rErr     <= 1'b0;
      rWr      <= 1'b0;
      rWdata   <= '0;
      rRdata   <= '0;
    end else begin
      rState   <= wNextState;
      rStrobes <= wNextStrobes;
      rBusOut  <= wNextBusOut;
      rDone    <= wNextDone;
      rErr     <= wNextErr;
      if (rState == IDLE && bus.req) begin
        rWr    <= bus.wr;
        rWdata <= bus.wdata;
      end
      if (rState == CAP) begin
        rRdata <= bus.BusMuxInMDR;
      end
    end
  end

  assign bus.ready    = (rState == IDLE);
  assign bus.done     = rDone;
  assign bus.err      = rErr;
  assign bus.rdata    = rRdata;
  assign bus.BusOut   = rBusOut;
  assign bus.BusDrive = rStrobes.BusDrive;
  assign bus.MARin    = rStrobes.MARin;
  assign bus.MDRin    = rStrobes.MDRin;
  assign bus.MDRread  = rStrobes.MDRread;
  assign bus.W_sig    = rStrobes.W_sig;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_access_ctrl                                     |
// | Description : Bench with MAR/MDR/RAM model and word-level scoreboard.|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_mem_access_ctrl;

  logic clk;
  logic clearN;

  mem_access_ctrl_if #(.DATA_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .Clock (clk),
    .Clear (clearN),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory subsystem: MAR, MDR and a RAM with a registered read address.
  logic [31:0] ram [0:511];
  logic [8:0]  mar;
  logic [8:0]  ramAddr;
  logic [31:0] mdr;
  logic [31:0] busVal;

  assign busVal          = bus.BusDrive ? bus.BusOut : 32'd0;
  assign bus.BusMuxInMDR = mdr;

  always @(posedge clk) begin
    if (bus.MARin) mar <= busVal[8:0];
    if (bus.MDRin) mdr <= bus.MDRread ? ram[ramAddr] : busVal;
    if (bus.W_sig) ram[mar] <= mdr;
    ramAddr <= mar;
  end

  // Word-level reference: what a correct controller leaves in memory.
  logic [31:0] refMem [0:511];
  logic [31:0] lastRd;

  int passCnt = 0;
  int totalCnt = 0;
  int protoErrs = 0;
  logic tbBusy = 1'b0;

  logic [4:0]  strbLog [0:15];
  logic [31:0] busLog  [0:15];
  longint      doneTime;

  function automatic logic [4:0] strobes();
    return {bus.MARin, bus.MDRin, bus.MDRread, bus.W_sig, bus.BusDrive};
  endfunction

  always @(negedge clk) begin
    if ((32'(bus.MARin) + 32'(bus.MDRin) + 32'(bus.W_sig)) > 1) protoErrs++;
    if (!bus.BusDrive && bus.BusOut != 32'd0) protoErrs++;
    if (bus.ready && tbBusy) protoErrs++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic hold, input logic [31:0] nextA, output int lat);
    int waited = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
    while (!bus.ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    tbBusy = 1'b1;
    if (hold) begin
      bus.addr = nextA;
    end else begin
      bus.req   = 1'b0;
      bus.wr    = 1'($urandom_range(0, 1));
      bus.addr  = $urandom;
      bus.wdata = $urandom;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      strbLog[lat] = strobes();
      busLog[lat]  = bus.BusOut;
    end while (!bus.done && lat < 15);
    tbBusy   = 1'b0;
    doneTime = $time;
  endtask

  // Apply one request and compare against the word-level model.
  task automatic checkedAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input string tag);
    int lat;
    logic oor;
    oor = (a[31:9] != 23'd0);
    access(w, a, d, 1'b0, 32'd0, lat);
    if (oor) begin
      check({tag, "_err_lat"}, 32'(lat), 32'd1);
      check({tag, "_err"}, 32'(bus.err), 32'd1);
      check({tag, "_err_rdata"}, bus.rdata, lastRd);
      check({tag, "_err_strb"}, 32'(strbLog[1]), 32'd0);
    end else if (w) begin
      check({tag, "_st_lat"}, 32'(lat), 32'd4);
      check({tag, "_st_err"}, 32'(bus.err), 32'd0);
      refMem[a[8:0]] = d;
    end else begin
      check({tag, "_ld_lat"}, 32'(lat), 32'd5);
      check({tag, "_ld_err"}, 32'(bus.err), 32'd0);
      check({tag, "_ld_rdata"}, bus.rdata, refMem[a[8:0]]);
      lastRd = refMem[a[8:0]];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    longint t1, t2, t3;
    for (int i = 0; i < 512; i++) begin
      ram[i] = 32'd0;
      refMem[i] = 32'd0;
    end
    lastRd = 32'd0;
    mar = 9'd0; ramAddr = 9'd0; mdr = 32'd0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    clearN = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    check("rst_strobes", 32'(strobes()), 32'd0);
    check("rst_busout", bus.BusOut, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    clearN = 1'b1;

    // Directed store with cycle-by-cycle strobe timing.
    access(1'b1, 32'h005, 32'hDEADBEEF, 1'b0, 32'd0, lat);
    refMem[5] = 32'hDEADBEEF;
    check("st_c1_strb", 32'(strbLog[1]), 32'b10001);
    check("st_c1_bus", busLog[1], 32'h005);
    check("st_c2_strb", 32'(strbLog[2]), 32'b01001);
    check("st_c2_bus", busLog[2], 32'hDEADBEEF);
    check("st_c3_strb", 32'(strbLog[3]), 32'b00010);
    check("st_lat", 32'(lat), 32'd4);
    check("st_err", 32'(bus.err), 32'd0);

    access(1'b0, 32'h005, 32'd0, 1'b0, 32'd0, lat);
    check("ld5_c3_strb", 32'(strbLog[3]), 32'b01100);
    check("ld5_lat", 32'(lat), 32'd5);
    check("ld5_rdata", bus.rdata, 32'hDEADBEEF);
    lastRd = 32'hDEADBEEF;
    checkedAccess(1'b0, 32'h1FF, 32'd0, "ld1ff");

    // Out-of-range store, then a normal load.
    checkedAccess(1'b1, 32'h200, 32'h0BADF00D, "oor");
    checkedAccess(1'b0, 32'h000, 32'd0, "ld0");

    // Preload, then a held request with addr changing mid-access.
    checkedAccess(1'b1, 32'h001, 32'h11111111, "pre1");
    checkedAccess(1'b1, 32'h002, 32'h22222222, "pre2");
    checkedAccess(1'b1, 32'h003, 32'h33333333, "pre3");
    access(1'b0, 32'h001, 32'd0, 1'b1, 32'h002, lat);
    t1 = doneTime;
    check("hold1_rdata", bus.rdata, 32'h11111111);
    access(1'b0, 32'h002, 32'd0, 1'b1, 32'h003, lat);
    t2 = doneTime;
    check("hold2_rdata", bus.rdata, 32'h22222222);
    access(1'b0, 32'h003, 32'd0, 1'b0, 32'd0, lat);
    t3 = doneTime;
    check("hold3_rdata", bus.rdata, 32'h33333333);
    check("hold_gap12", 32'(t2 - t1), 32'd60);
    check("hold_gap23", 32'(t3 - t2), 32'd60);
    lastRd = 32'h33333333;

    // Reset during MDR_ST of a store leaves memory untouched.
    checkedAccess(1'b1, 32'h010, 32'hCAFEF00D, "pre10");
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h010; bus.wdata = 32'h12345678;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_in_mdrst", 32'(strobes()), 32'b01001);
    #2;
    clearN = 1'b0;
    #1;
    check("rstmid_ready", 32'(bus.ready), 32'd1);
    check("rstmid_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    check("rstmid_strobes", 32'(strobes()), 32'd0);
    check("rstmid_busout", bus.BusOut, 32'd0);
    check("rstmid_rdata", bus.rdata, 32'd0);
    lastRd = 32'd0;
    @(negedge clk);
    clearN = 1'b1;
    checkedAccess(1'b0, 32'h010, 32'd0, "ld10_after_rst");

    // Random mix; small address window so loads hit prior stores often.
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a;
      logic w;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) a = 32'h200 + 32'($urandom_range(0, 4096));
      else if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 511));
      else a = 32'($urandom_range(0, 15));
      checkedAccess(w, a, $urandom, "rnd");
    end

    check("protocol_violations", 32'(protoErrs), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
`default_nettype wire
